engine_sequencer: RTL and testbench

ENGINE_SEQUENCER -- requirements
Module: engine_sequencer

---
 rtl/engine_sequencer_if.sv | 59 +++++
 rtl/engine_sequencer.sv | 154 +++++++++++++++
 tb/tb_engine_sequencer.sv | 323 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/engine_sequencer_if.sv
// Shared beat sideband type and the handshake bundle between the engine sequencer,
// its configuration/pixel source and the processing engine.
`ifndef KW_MAX
`define KW_MAX 7
`endif
`ifndef SW_MAX
`define SW_MAX 4
`endif

package engine_sequencer_pkg;
  localparam int KW2_W = $clog2(`KW_MAX / 2 + 1);
  localparam int SW1_W = $clog2(`SW_MAX);

  // Sideband carried with every engine beat; fields not owned by the sequencer stay zero.
  typedef struct packed {
    logic             is_not_max;
    logic             is_max;
    logic             is_lrelu;
    logic             is_w_last;
    logic             is_w_first_kw2;
    logic             is_config;
    logic             is_cin_last;
    logic             is_w_first_clk;
    logic [KW2_W-1:0] kw2;
    logic [SW1_W-1:0] sw_1;
  } tuser_st;
endpackage

interface engine_sequencer_if #(
  parameter int CIN_BITS = 10,
  parameter int ITR_BITS = 10
);
  import engine_sequencer_pkg::*;

  logic                cfg_valid;
  logic                cfg_ready;
  logic [KW2_W-1:0]    cfg_kw2;
  logic [SW1_W-1:0]    cfg_sw_1;
  logic [CIN_BITS-1:0] cfg_cin_1;
  logic [ITR_BITS-1:0] cfg_itr_1;
  logic                s_valid;
  logic                s_ready;
  logic                m_valid;
  logic                m_ready;
  logic                m_last;
  tuser_st             m_user;

  // Environment side: issues configurations and upstream beats, sinks engine beats.
  modport master (
    output cfg_valid, cfg_kw2, cfg_sw_1, cfg_cin_1, cfg_itr_1, s_valid, m_ready,
    input  cfg_ready, s_ready, m_valid, m_last, m_user
  );

  // Sequencer side.
  modport slave (
    input  cfg_valid, cfg_kw2, cfg_sw_1, cfg_cin_1, cfg_itr_1, s_valid, m_ready,
    output cfg_ready, s_ready, m_valid, m_last, m_user
  );
endinterface

// File: rtl/engine_sequencer.sv
// Engine sequencer: per configuration, emits one config beat then cin_1+1 data beats,
// repeated itr_1+1 times, tagging each beat with its position sideband.
`ifndef KW_MAX
`define KW_MAX 7
`endif
`ifndef SW_MAX
`define SW_MAX 4
`endif

module engine_sequencer
  import engine_sequencer_pkg::*;
#(
  parameter int KW_MAX   = `KW_MAX,
  parameter int SW_MAX   = `SW_MAX,
  parameter int CIN_BITS = 10,
  parameter int ITR_BITS = 10
) (
  input  logic              clk,
  input  logic              resetn,
  engine_sequencer_if.slave bus
);

  localparam int KW2_BITS = $clog2(KW_MAX / 2 + 1);
  localparam int SW1_BITS = $clog2(SW_MAX);
  localparam logic [CIN_BITS-1:0] CIN_ONE = {{(CIN_BITS-1){1'b0}}, 1'b1};
  localparam logic [ITR_BITS-1:0] ITR_ONE = {{(ITR_BITS-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CONFIG = 2'd1,
    ST_DATA   = 2'd2
  } state_t;

  state_t              state_r;
  logic [CIN_BITS-1:0] cin_cnt_r;
  logic [ITR_BITS-1:0] itr_cnt_r;
  logic [KW2_BITS-1:0] kw2_r;
  logic [SW1_BITS-1:0] sw_1_r;
  logic [CIN_BITS-1:0] cin_1_r;
  logic [ITR_BITS-1:0] itr_1_r;
  logic                cfg_ready_r;
  logic                cfg_beat_r;
  logic                data_r;
  logic                cin_last_r;
  logic                w_first_r;
  logic                last_r;

  logic [CIN_BITS-1:0] cin_next_s;
  logic [ITR_BITS-1:0] itr_next_s;
  logic                data_xfer_s;
  logic                itr_last_s;
  tuser_st             user_s;

  assign cin_next_s  = cin_cnt_r + CIN_ONE;
  assign itr_next_s  = itr_cnt_r + ITR_ONE;
  assign itr_last_s  = (itr_cnt_r == itr_1_r);
  assign data_xfer_s = data_r & bus.s_valid & bus.m_ready;

  // Sequencer state, counters, latched configuration and per-beat sideband flags.
  // Flags are precomputed one transfer ahead so every output is a register decode.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_r     <= ST_IDLE;
      cin_cnt_r   <= '0;
      itr_cnt_r   <= '0;
      kw2_r       <= '0;
      sw_1_r      <= '0;
      cin_1_r     <= '0;
      itr_1_r     <= '0;
      cfg_ready_r <= 1'b1;
      cfg_beat_r  <= 1'b0;
      data_r      <= 1'b0;
      cin_last_r  <= 1'b0;
      w_first_r   <= 1'b0;
      last_r      <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.cfg_valid) begin
            kw2_r       <= bus.cfg_kw2;
            sw_1_r      <= bus.cfg_sw_1;
            cin_1_r     <= bus.cfg_cin_1;
            itr_1_r     <= bus.cfg_itr_1;
            cin_cnt_r   <= '0;
            itr_cnt_r   <= '0;
            cfg_ready_r <= 1'b0;
            cfg_beat_r  <= 1'b1;
            state_r     <= ST_CONFIG;
          end
        end
        ST_CONFIG: begin
          if (bus.m_ready) begin
            cfg_beat_r <= 1'b0;
            data_r     <= 1'b1;
            cin_last_r <= (cin_1_r == '0);
            w_first_r  <= (itr_cnt_r == '0);
            last_r     <= (cin_1_r == '0) && itr_last_s;
            state_r    <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (data_xfer_s) begin
            w_first_r <= 1'b0;
            if (cin_last_r) begin
              data_r     <= 1'b0;
              cin_last_r <= 1'b0;
              last_r     <= 1'b0;
              cin_cnt_r  <= '0;
              if (itr_last_s) begin
                cfg_ready_r <= 1'b1;
                state_r     <= ST_IDLE;
              end else begin
                itr_cnt_r  <= itr_next_s;
                cfg_beat_r <= 1'b1;
                state_r    <= ST_CONFIG;
              end
            end else begin
              cin_cnt_r  <= cin_next_s;
              cin_last_r <= (cin_next_s == cin_1_r);
              last_r     <= (cin_next_s == cin_1_r) && itr_last_s;
            end
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          cfg_ready_r <= 1'b1;
          cfg_beat_r  <= 1'b0;
          data_r      <= 1'b0;
          cin_last_r  <= 1'b0;
          w_first_r   <= 1'b0;
          last_r      <= 1'b0;
        end
      endcase
    end
  end

  // Sideband assembly; fields owned by other stages are tied low.
  always_comb begin
    user_s                = '0;
    user_s.is_config      = cfg_beat_r;
    user_s.is_cin_last    = cin_last_r;
    user_s.is_w_first_clk = w_first_r;
    user_s.kw2            = kw2_r;
    user_s.sw_1           = sw_1_r;
  end

  // In DATA the upstream handshake passes straight through with no added latency.
  assign bus.cfg_ready = cfg_ready_r;
  assign bus.m_valid   = data_r ? bus.s_valid : cfg_beat_r;
  assign bus.s_ready   = data_r & bus.m_ready;
  assign bus.m_last    = last_r;
  assign bus.m_user    = user_s;

endmodule

// File: tb/tb_engine_sequencer.sv
// Directed bench for engine_sequencer: beat sequences, stalls, reset and config isolation.
module tb_engine_sequencer;
  import engine_sequencer_pkg::*;

  logic clk;
  logic resetn;
  int   checks;
  int   failures;

  engine_sequencer_if ifc ();

  engine_sequencer dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {m_valid, s_ready, is_config, is_cin_last, is_w_first_clk, m_last}
  function automatic logic [5:0] beat_sig();
    return {ifc.m_valid, ifc.s_ready, ifc.m_user.is_config, ifc.m_user.is_cin_last,
            ifc.m_user.is_w_first_clk, ifc.m_last};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cfg(input logic [1:0] kw2, input logic [1:0] sw_1,
                          input logic [9:0] cin_1, input logic [9:0] itr_1);
    ifc.cfg_kw2   = kw2;
    ifc.cfg_sw_1  = sw_1;
    ifc.cfg_cin_1 = cin_1;
    ifc.cfg_itr_1 = itr_1;
    ifc.cfg_valid = 1'b1;
    step();
    ifc.cfg_valid = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    ifc.cfg_valid = 1'b0; ifc.s_valid = 1'b0; ifc.m_ready = 1'b0;
    ifc.cfg_kw2 = '0; ifc.cfg_sw_1 = '0; ifc.cfg_cin_1 = '0; ifc.cfg_itr_1 = '0;
    step();
    step();
    @(negedge clk);
    checks++;
    if ({ifc.cfg_ready, beat_sig()} !== 7'b1000000) begin
      failures++;
      $display("FAIL reset_outputs: got %b required %b", {ifc.cfg_ready, beat_sig()}, 7'b1000000);
    end
    checks++;
    if (ifc.m_user !== '0) begin
      failures++;
      $display("FAIL reset_m_user: got %h required 0", ifc.m_user);
    end
    step();
    resetn = 1'b1;
    step();
  endtask

  task automatic test_basic();
    logic [5:0] exp_sig [8] = '{6'b101000, 6'b110010, 6'b110000, 6'b110100,
                                6'b101000, 6'b110000, 6'b110000, 6'b110101};
    ifc.s_valid = 1'b1; ifc.m_ready = 1'b1;
    send_cfg(2'd1, 2'd0, 10'd2, 10'd1);
    for (int b = 0; b < 8; b++) begin
      @(negedge clk);
      checks++;
      if (beat_sig() !== exp_sig[b]) begin
        failures++;
        $display("FAIL basic_beat%0d: got %b required %b", b, beat_sig(), exp_sig[b]);
      end
      checks++;
      if ({ifc.m_user.kw2, ifc.m_user.sw_1} !== 4'b0100) begin
        failures++;
        $display("FAIL basic_kw2_sw1 beat%0d: got %b required %b", b,
                 {ifc.m_user.kw2, ifc.m_user.sw_1}, 4'b0100);
      end
      step();
    end
    ifc.s_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({ifc.cfg_ready, ifc.m_valid} !== 2'b10) begin
      failures++;
      $display("FAIL basic_idle: got %b required %b", {ifc.cfg_ready, ifc.m_valid}, 2'b10);
    end
    step();
  endtask

  task automatic test_back_to_back();
    logic [5:0] exp_a [2] = '{6'b101000, 6'b110111};
    logic [5:0] exp_b [3] = '{6'b101000, 6'b110010, 6'b110101};
    ifc.s_valid = 1'b1; ifc.m_ready = 1'b1;
    send_cfg(2'd2, 2'd1, 10'd0, 10'd0);
    for (int b = 0; b < 2; b++) begin
      @(negedge clk);
      checks++;
      if (beat_sig() !== exp_a[b]) begin
        failures++;
        $display("FAIL single_beat%0d: got %b required %b", b, beat_sig(), exp_a[b]);
      end
      step();
    end
    ifc.cfg_kw2 = 2'd1; ifc.cfg_sw_1 = 2'd2; ifc.cfg_cin_1 = 10'd1; ifc.cfg_itr_1 = 10'd0;
    ifc.cfg_valid = 1'b1;
    @(negedge clk);
    checks++;
    if ({ifc.cfg_ready, ifc.m_valid} !== 2'b10) begin
      failures++;
      $display("FAIL b2b_idle_ready: got %b required %b", {ifc.cfg_ready, ifc.m_valid}, 2'b10);
    end
    step();
    ifc.cfg_valid = 1'b0;
    for (int b = 0; b < 3; b++) begin
      @(negedge clk);
      checks++;
      if ({beat_sig(), ifc.m_user.kw2, ifc.m_user.sw_1} !== {exp_b[b], 4'b0110}) begin
        failures++;
        $display("FAIL b2b_beat%0d: got %b required %b", b,
                 {beat_sig(), ifc.m_user.kw2, ifc.m_user.sw_1}, {exp_b[b], 4'b0110});
      end
      step();
    end
    ifc.s_valid = 1'b0;
    step();
  endtask

  task automatic test_config_stall();
    logic [5:0] exp_sig [3] = '{6'b101000, 6'b110010, 6'b110101};
    ifc.s_valid = 1'b1; ifc.m_ready = 1'b0;
    send_cfg(2'd3, 2'd3, 10'd1, 10'd0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if ({beat_sig(), ifc.m_user.kw2, ifc.m_user.sw_1} !== 10'b1010001111) begin
        failures++;
        $display("FAIL stall_cycle%0d: got %b required %b", c,
                 {beat_sig(), ifc.m_user.kw2, ifc.m_user.sw_1}, 10'b1010001111);
      end
      step();
    end
    ifc.m_ready = 1'b1;
    for (int b = 0; b < 3; b++) begin
      @(negedge clk);
      checks++;
      if (beat_sig() !== exp_sig[b]) begin
        failures++;
        $display("FAIL stall_beat%0d: got %b required %b", b, beat_sig(), exp_sig[b]);
      end
      step();
    end
    ifc.s_valid = 1'b0;
    step();
  endtask

  task automatic test_random_handshake();
    int  data_n = 0, cfg_n = 0, last_n = 0, cin_pos = 0, itr = 0;
    bit  in_cfg = 1'b1, done = 1'b0;
    ifc.s_valid = 1'b0; ifc.m_ready = 1'b0;
    send_cfg(2'd1, 2'd1, 10'd5, 10'd3);
    for (int cyc = 0; cyc < 1000 && !done; cyc++) begin
      ifc.s_valid = ($urandom_range(0, 3) != 0);
      ifc.m_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (ifc.m_last === 1'b1 && ifc.m_valid === 1'b1 && ifc.m_ready === 1'b1) last_n++;
      if (in_cfg) begin
        checks++;
        if ({ifc.m_valid, ifc.s_ready, ifc.m_user.is_config} !== 3'b101) begin
          failures++;
          $display("FAIL rand_config cyc%0d: got %b required %b", cyc,
                   {ifc.m_valid, ifc.s_ready, ifc.m_user.is_config}, 3'b101);
        end
        if (ifc.m_ready) begin
          cfg_n++;
          in_cfg = 1'b0;
        end
      end else begin
        checks++;
        if ({ifc.m_valid, ifc.s_ready, ifc.m_user.is_config} !==
            {ifc.s_valid, ifc.m_ready, 1'b0}) begin
          failures++;
          $display("FAIL rand_passthru cyc%0d: got %b required %b", cyc,
                   {ifc.m_valid, ifc.s_ready, ifc.m_user.is_config},
                   {ifc.s_valid, ifc.m_ready, 1'b0});
        end
        if (ifc.s_valid && ifc.m_ready) begin
          data_n++;
          checks++;
          if ({ifc.m_user.is_cin_last, ifc.m_user.is_w_first_clk, ifc.m_last} !==
              {cin_pos == 5, itr == 0 && cin_pos == 0, itr == 3 && cin_pos == 5}) begin
            failures++;
            $display("FAIL rand_flags xfer%0d: got %b required %b", data_n,
                     {ifc.m_user.is_cin_last, ifc.m_user.is_w_first_clk, ifc.m_last},
                     {cin_pos == 5, itr == 0 && cin_pos == 0, itr == 3 && cin_pos == 5});
          end
          if (cin_pos == 5) begin
            cin_pos = 0;
            if (itr == 3) done = 1'b1;
            else begin
              itr++;
              in_cfg = 1'b1;
            end
          end else begin
            cin_pos++;
          end
        end
      end
      step();
    end
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL rand_timeout: got %0d transfers required completion", data_n);
    end
    checks++;
    if (data_n != 24 || cfg_n != 4 || last_n != 1) begin
      failures++;
      $display("FAIL rand_counts: got data=%0d cfg=%0d last=%0d required 24 4 1",
               data_n, cfg_n, last_n);
    end
    ifc.s_valid = 1'b0; ifc.m_ready = 1'b0;
    @(negedge clk);
    checks++;
    if ({ifc.cfg_ready, ifc.m_valid} !== 2'b10) begin
      failures++;
      $display("FAIL rand_idle: got %b required %b", {ifc.cfg_ready, ifc.m_valid}, 2'b10);
    end
    step();
  endtask

  task automatic test_reset_mid_data();
    logic [5:0] exp_sig [2] = '{6'b101000, 6'b110111};
    ifc.s_valid = 1'b1; ifc.m_ready = 1'b1;
    send_cfg(2'd1, 2'd0, 10'd3, 10'd1);
    for (int b = 0; b < 3; b++) begin
      @(negedge clk);
      checks++;
      if (ifc.m_last !== 1'b0) begin
        failures++;
        $display("FAIL rst_pre_last beat%0d: got %b required 0", b, ifc.m_last);
      end
      step();
    end
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    @(negedge clk);
    checks++;
    if ({ifc.cfg_ready, ifc.m_valid, ifc.s_ready, ifc.m_last} !== 4'b1000) begin
      failures++;
      $display("FAIL rst_mid_state: got %b required %b",
               {ifc.cfg_ready, ifc.m_valid, ifc.s_ready, ifc.m_last}, 4'b1000);
    end
    checks++;
    if (ifc.m_user !== '0) begin
      failures++;
      $display("FAIL rst_mid_user: got %h required 0", ifc.m_user);
    end
    step();
    send_cfg(2'd2, 2'd1, 10'd0, 10'd0);
    for (int b = 0; b < 2; b++) begin
      @(negedge clk);
      checks++;
      if ({beat_sig(), ifc.m_user.kw2, ifc.m_user.sw_1} !== {exp_sig[b], 4'b1001}) begin
        failures++;
        $display("FAIL rst_rerun_beat%0d: got %b required %b", b,
                 {beat_sig(), ifc.m_user.kw2, ifc.m_user.sw_1}, {exp_sig[b], 4'b1001});
      end
      step();
    end
    ifc.s_valid = 1'b0;
    step();
  endtask

  task automatic test_cfg_ignored();
    logic [5:0] exp_sig [5] = '{6'b101000, 6'b110010, 6'b110000, 6'b110000, 6'b110101};
    ifc.s_valid = 1'b1; ifc.m_ready = 1'b1;
    send_cfg(2'd2, 2'd1, 10'd3, 10'd0);
    for (int b = 0; b < 5; b++) begin
      ifc.cfg_valid = (b == 1 || b == 3);
      ifc.cfg_kw2 = 2'd1; ifc.cfg_sw_1 = 2'd3; ifc.cfg_cin_1 = 10'd0; ifc.cfg_itr_1 = 10'd0;
      @(negedge clk);
      checks++;
      if ({ifc.cfg_ready, beat_sig(), ifc.m_user.kw2, ifc.m_user.sw_1} !==
          {1'b0, exp_sig[b], 4'b1001}) begin
        failures++;
        $display("FAIL cfg_ignore_beat%0d: got %b required %b", b,
                 {ifc.cfg_ready, beat_sig(), ifc.m_user.kw2, ifc.m_user.sw_1},
                 {1'b0, exp_sig[b], 4'b1001});
      end
      step();
    end
    ifc.cfg_valid = 1'b0;
    ifc.s_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({ifc.cfg_ready, ifc.m_valid} !== 2'b10) begin
      failures++;
      $display("FAIL cfg_ignore_idle: got %b required %b", {ifc.cfg_ready, ifc.m_valid}, 2'b10);
    end
    step();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_config_stall();
    test_random_handshake();
    test_reset_mid_data();
    test_cfg_ignored();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
